// File: rtl/mul_add_seq.sv
// -----------------------------------------------------------------------------
// mul_add_seq
// Sequential multi-limb multiply-accumulate engine used by the MonPro inner
// loop. One row computes
//     {C, S[len-1:0]} = x * Y + Z + c_in
// where Y and Z arrive as little-endian limbs, one limb per accepted beat.
// A single limb-wide multiplier is reused for every limb; the inter-limb
// carry (the upper half of each partial result) is kept in a register.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           row start request, only honoured while busy=0
//   x, c_in         row multiplier and initial carry, latched at start
//   len             limbs in the row (0..NUM_WORDS, larger values clamp)
//   add_z           1: add z limbs, 0: treat z as zero; latched at start
//   busy            row in progress
//   in_valid/in_ready, y, z       input limb stream
//   out_valid/out_ready, out_data, out_last   result limb stream
//   done            one-cycle pulse when the row has fully drained
//   c_out           final carry, valid from done until the next row's done
// -----------------------------------------------------------------------------
module mul_add_seq #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 16,
  parameter int CNT_W      = $clog2(NUM_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] c_in,
  input  logic [CNT_W-1:0]      len,
  input  logic                  add_z,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] c_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(NUM_WORDS);

  state_t state;
  state_t state_next;

  // Row context captured at start
  logic [DATA_WIDTH-1:0] x_q;
  logic                  add_z_q;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] carry_q;

  // Handshake / control strobes produced by the FSM
  logic start_accept;
  logic in_hs;
  logic out_hs;
  logic last_idx;

  logic [CNT_W-1:0] len_clamped;

  // Full-width partial result of one limb
  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] addend;
  logic [2*DATA_WIDTH-1:0] t_sum;

  // Out-of-range lengths are treated as a full-width row rather than
  // running the counter past the end of the operand.
  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  assign last_idx = (idx_q == (len_q - CNT_W'(1)));
  assign out_hs   = out_valid && out_ready;

  // The sum cannot overflow 2*DATA_WIDTH bits: the worst case
  // (2^W-1)^2 + 2*(2^W-1) is exactly 2^(2W)-1.
  always_comb begin
    prod   = {{DATA_WIDTH{1'b0}}, x_q} * {{DATA_WIDTH{1'b0}}, y};
    addend = add_z_q ? {{DATA_WIDTH{1'b0}}, z} : '0;
    t_sum  = prod + addend + {{DATA_WIDTH{1'b0}}, carry_q};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake logic. The output slot is a single register
  // with no skid buffer, so a new limb is only taken when the slot is empty
  // or is being drained in this same cycle.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    in_hs        = 1'b0;
    start_accept = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        start_accept = start;
        if (start && (len_clamped != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        in_hs    = in_valid && in_ready;
        if (in_hs && last_idx) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (out_hs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Row context, carry chain and output slot. A zero-length row completes
  // immediately: the initial carry is reported as the final carry on the
  // following cycle without producing any output beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      add_z_q   <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      carry_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      c_out     <= '0;
    end else begin
      done <= 1'b0;

      if (start_accept) begin
        x_q     <= x;
        add_z_q <= add_z;
        len_q   <= len_clamped;
        idx_q   <= '0;
        carry_q <= c_in;
        if (len_clamped == '0) begin
          done  <= 1'b1;
          c_out <= c_in;
        end
      end

      if (in_hs) begin
        out_data  <= t_sum[DATA_WIDTH-1:0];
        out_valid <= 1'b1;
        out_last  <= last_idx;
        carry_q   <= t_sum[2*DATA_WIDTH-1:DATA_WIDTH];
        idx_q     <= idx_q + CNT_W'(1);
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if ((state == FLUSH) && out_hs) begin
        done  <= 1'b1;
        c_out <= carry_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_add_seq
// Scoreboard bench for mul_add_seq with 8-bit limbs and up to 4 limbs per row.
// Each row is evaluated as one wide integer (x * Y + Z + c_in); the expected
// result limbs and final carry are queued when the row is issued, and a
// separate monitor pops and compares them as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_mul_add_seq;

  localparam int W  = 8;
  localparam int NW = 4;
  localparam int CW = $clog2(NW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  c_in = '0;
  logic [CW-1:0] len = '0;
  logic          add_z = 1'b0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  y = '0;
  logic [W-1:0]  z = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          done;
  logic [W-1:0]  c_out;

  mul_add_seq #(
    .DATA_WIDTH(W),
    .NUM_WORDS (NW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x        (x),
    .c_in     (c_in),
    .len      (len),
    .add_z    (add_z),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .z        (z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done),
    .c_out    (c_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t        beat_q[$];
  logic [W-1:0] cout_q[$];

  // Downstream ready control
  int bp_cnt     = 0;
  bit stall_arm  = 1'b0;
  bit rand_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout/unexpected expected event at %0t", name, $time);
  endtask

  // Drives out_ready: a programmed 3-cycle stall once armed and the first
  // beat is seen, otherwise random or always-ready.
  always @(posedge clk) begin
    #1;
    if (stall_arm && out_valid) begin
      stall_arm = 1'b0;
      bp_cnt    = 3;
    end
    if (bp_cnt > 0) begin
      out_ready = 1'b0;
      bp_cnt--;
    end else if (rand_ready) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: compares every presented beat and every done pulse against
  // the scoreboard, and checks output stability under backpressure.
  beat_t        mon_b;
  logic         prev_stall = 1'b0;
  logic         prev_last_hs = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_last_hs) checkOutput("done_timing", 64'(done), 64'(1));
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(out_valid), 64'(1));
        checkOutput("hold_data", 64'(out_data), 64'(prev_data));
        checkOutput("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && !out_ready) checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          flagFail("unexpected_beat");
        end else begin
          mon_b = beat_q.pop_front();
          checkOutput("out_data", 64'(out_data), 64'(mon_b.data));
          checkOutput("out_last", 64'(out_last), 64'(mon_b.last));
        end
      end
      if (done) begin
        if (cout_q.size() == 0) begin
          flagFail("unexpected_done");
        end else begin
          checkOutput("c_out", 64'(c_out), 64'(cout_q.pop_front()));
        end
      end
      prev_stall   = out_valid && !out_ready;
      prev_last_hs = out_valid && out_ready && out_last;
      prev_data    = out_data;
      prev_last    = out_last;
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    checkOutput({tag, "_out_data"}, 64'(out_data), 64'(0));
    checkOutput({tag, "_out_last"}, 64'(out_last), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_c_out"}, 64'(c_out), 64'(0));
  endtask

  // Issues one row. abort_after >= 0 resets the DUT after that many limbs;
  // poke re-asserts start with garbage operands while the row is busy.
  task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] cv,
                               input int lenv, input logic az,
                               input logic [NW*W-1:0] yp, input logic [NW*W-1:0] zp,
                               input int abort_after, input bit poke);
    int              leff;
    int              waitc;
    bit              hs;
    longint unsigned yv;
    longint unsigned zv;
    longint unsigned total;
    beat_t           b;

    waitc = 0;
    while (busy !== 1'b0 && waitc < 500) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    if (waitc >= 500) begin
      flagFail("wait_idle");
      return;
    end

    leff = (lenv > NW) ? NW : lenv;
    yv = 0;
    zv = 0;
    for (int i = 0; i < leff; i++) begin
      yv |= 64'(yp[W*i +: W]) << (W * i);
      zv |= 64'(zp[W*i +: W]) << (W * i);
    end
    total = 64'(xv) * yv + (az ? zv : 64'd0) + 64'(cv);
    for (int i = 0; i < leff; i++) begin
      b.data = W'(total >> (W * i));
      b.last = (i == leff - 1);
      beat_q.push_back(b);
    end
    if (abort_after < 0) cout_q.push_back(W'(total >> (W * leff)));

    start = 1'b1;
    x     = xv;
    c_in  = cv;
    len   = CW'(lenv);
    add_z = az;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = W'($urandom);
    c_in  = W'($urandom);
    len   = CW'($urandom);
    add_z = 1'($urandom);

    if (leff == 0) begin
      @(negedge clk);
      checkOutput("len0_done", 64'(done), 64'(1));
      checkOutput("len0_busy", 64'(busy), 64'(0));
    end

    for (int i = 0; i < leff; i++) begin
      if (abort_after == i) break;
      in_valid = 1'b1;
      y = yp[W*i +: W];
      z = zp[W*i +: W];
      if (poke && i == 1) begin
        start = 1'b1;
        len   = '0;
      end
      waitc = 0;
      hs    = 1'b0;
      do begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitc++;
      end while (!hs && waitc < 200);
      if (!hs) begin
        flagFail("in_handshake");
        break;
      end
    end
    in_valid = 1'b0;
    y = W'($urandom);
    z = W'($urandom);

    if (abort_after >= 0) begin
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      beat_q.delete();
      cout_q.delete();
      @(negedge clk);
      checkResetValues("abort");
    end else begin
      waitc = 0;
      while (busy !== 1'b0 && waitc < 500) begin
        @(posedge clk);
        #1;
        waitc++;
      end
      if (waitc >= 500) flagFail("row_complete");
    end
  endtask

  initial begin
    $display("[TB] mul_add_seq scoreboard bench");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Carry propagation between limbs
    applyStimulus(8'h80, 8'h00, 2, 1'b1, 32'h0000_0204, 32'h0000_0005, -1, 1'b0);
    @(negedge clk);
    checkOutput("carry_row_c_out", 64'(c_out), 64'h01);

    // All-ones operands reach exactly the top of the range
    applyStimulus(8'hFF, 8'hFF, 4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    @(negedge clk);
    checkOutput("max_row_c_out", 64'(c_out), 64'hFF);

    // z ignored when add_z=0
    applyStimulus(8'h80, 8'h00, 2, 1'b0, 32'h0000_0204, 32'h0000_0005, -1, 1'b0);
    @(negedge clk);
    checkOutput("noz_row_c_out", 64'(c_out), 64'h01);

    // Downstream stall of three cycles on the first beat
    stall_arm = 1'b1;
    applyStimulus(8'h3C, 8'h11, 3, 1'b1, 32'h0077_55AA, 32'h0012_3456, -1, 1'b0);

    // Zero-length row reports the initial carry
    applyStimulus(8'h99, 8'h5A, 0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, -1, 1'b0);
    @(negedge clk);
    checkOutput("len0_c_out", 64'(c_out), 64'h5A);

    // Reset after two of four limbs, then a clean row
    applyStimulus(8'hC3, 8'h21, 4, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("post_abort_done", 64'(done), 64'(0));
    applyStimulus(8'h80, 8'h00, 2, 1'b1, 32'h0000_0204, 32'h0000_0005, -1, 1'b0);
    @(negedge clk);
    checkOutput("post_abort_c_out", 64'(c_out), 64'h01);

    // start while busy must not disturb the row
    applyStimulus(8'hA5, 8'h0F, 4, 1'b1, 32'h0102_0304, 32'hF0E0_D0C0, -1, 1'b1);

    // len beyond NUM_WORDS clamps to a full row
    applyStimulus(8'h7E, 8'h81, 7, 1'b1, 32'h89AB_CDEF, 32'h7654_3210, -1, 1'b0);

    // Random rows under random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 30; r++) begin
      applyStimulus(W'($urandom), W'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                    32'($urandom), 32'($urandom), -1, 1'($urandom_range(0, 3) == 0));
    end
    rand_ready = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("beats_left", 64'(beat_q.size()), 64'(0));
    checkOutput("couts_left", 64'(cout_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
- Sequential multi-limb multiply-accumulate engine for MonPro.
- Computes the row {C, S[len-1:0]} = x * Y + Z + c_in, where Y and Z are streamed little-endian limbs of DATA_WIDTH bits, one limb per cycle.
- The inter-limb carry is held in a register, so a full MonPro inner-loop row runs with a single limb-wide multiplier.
- Valid/ready streams on both sides; full throughput is one limb per clock.

Parameters:
DATA_WIDTH, 128, limb width in bits
NUM_WORDS, 16, maximum limbs per row
CNT_W, $clog2(NUM_WORDS+1), width of len and the limb counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  row start request, sampled only while busy=0
x  input  DATA_WIDTH  row multiplier, latched at start
c_in  input  DATA_WIDTH  initial carry, latched at start
len  input  CNT_W  limbs in row (0..NUM_WORDS), latched at start
add_z  input  1  1: add z limbs; 0: treat z as zero; latched at start
busy  output  1  row in progress
in_valid  input  1  y/z limb valid
in_ready  output  1  limb accepted when in_valid&&in_ready
y  input  DATA_WIDTH  multiplicand limb i
z  input  DATA_WIDTH  addend limb i
out_valid  output  1  s limb valid
out_ready  input  1  downstream accepts s limb
out_data  output  DATA_WIDTH  s limb i
out_last  output  1  marks limb len-1
done  output  1  one-cycle pulse at row end
c_out  output  DATA_WIDTH  final carry; valid from done, held until next accepted start

Behaviour:
- Reset: all clocked logic uses `if (!rst_n)` inside `always @(posedge clk)`; no asynchronous reset.
- Reset values: busy=0, in_ready=0, out_valid=0, out_data=0, out_last=0, done=0, c_out=0, state=IDLE, counter=0, carry=0.
- Reset mid-row aborts the row silently: no done pulse, partial outputs discarded.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 latches x, c_in, len, add_z; carry<=c_in; idx<=0.
  - len>0: go to RUN, busy=1 from next cycle.
  - len==0: stay IDLE; next cycle done=1 and c_out=c_in; no out beats.
- RUN:
  - in_ready = !out_valid || out_ready (combinational; registered output slot with no skid buffer).
  - On input handshake: t = x*y + (add_z ? z : 0) + carry, computed at 2*DATA_WIDTH bits.
  - Next cycle: out_data=t[DATA_WIDTH-1:0], out_valid=1, out_last=(idx==len-1), carry<=t[2*DATA_WIDTH-1:DATA_WIDTH], idx<=idx+1.
  - Overflow impossible: max t = (2^W-1)^2 + 2(2^W-1) = 2^(2W)-1.
  - On accepting the limb with idx==len-1: go to FLUSH; in_ready=0.
- FLUSH: hold out_valid until out_ready; when the last beat handshakes, go to IDLE. Next cycle: done=1 for one cycle, c_out=carry, busy=0.
- Output hold: out_valid/out_data/out_last stay stable while out_valid && !out_ready.
- out_valid falls the cycle after the handshake unless a new limb was accepted that same cycle (back-to-back).
- Latency: input handshake to out_valid is 1 cycle; last out handshake to done is 1 cycle.
- start while busy=1 is ignored.
- start in the same cycle as done is accepted (state is IDLE).
- in_valid in IDLE or FLUSH is ignored (in_ready=0).
- len > NUM_WORDS: clamped to NUM_WORDS.
- done and c_out are independent of out_ready timing except through the last-beat handshake.

Test Plan:
- Bench uses DATA_WIDTH=8, NUM_WORDS=4.
- Carry propagation: x=0x80, c_in=0, add_z=1, len=2, y={0x04,0x02}, z={0x05,0x00}, out_ready=1 -> out_data 0x05 then 0x02, out_last on 2nd beat, done 1 cycle later with c_out=0x01, one beat per cycle.
- Max operands: x=0xFF, all y=z=0xFF, c_in=0xFF, len=4 -> every out_data=0xFF, c_out=0xFF, no overflow.
- add_z=0, same stimulus as the carry-propagation case -> out_data 0x00, 0x02; c_out=0x01 (z ignored).
- Backpressure:
  - Stimulus: len=3, out_ready low for 3 cycles after the first out_valid, in_valid held high.
  - Response: in_ready=0 while stalled; out_data stable; no limb lost or duplicated; done only after the 3rd handshake.
- len=0 with c_in=0x5A -> no out_valid; done pulse the cycle after start; c_out=0x5A; busy stays 0.
- Reset and start handling:
  - rst_n low for 1 cycle mid-row (after 2 of 4 limbs) -> all outputs return to reset values next cycle, no done.
  - A following row (x=0x80, y={0x04,0x02}, z={0x05,0x00}, c_in=0) -> c_out=0x01.
  - start asserted while busy -> ignored.
